pc_next_ctrl: RTL and testbench

Next-PC controller for the pipelined CPU fetch stage. Each cycle it chooses the value loaded into the PC register: sequential PC+4, EX-stage branch target, ID-stage jump target, or a held PC. It also drives the IF/ID flush signals, tracks halt state and counts redirects. It sits between hazard/branch logic and the PC register and owns all PC sequencing policy.

---
 rtl/pc_ctrl_pkg.sv | 32 +++
 rtl/pc_sel_mux.sv | 42 ++++
 rtl/pc_next_ctrl.sv | 155 +++++++++++++++
 tb/tb_pc_next_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the next-PC controller.
//   - pc_state_e : controller FSM states (RUN, HALTED)
//   - pc_sel_e   : 2-bit next-PC source select (SEQ, HOLD, BR, JMP)
//   - TRAP       : handled as a separate override line next to the 2-bit select
//   - PC_STEP, RESET_PC, TRAP_VEC constants
package pc_ctrl_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [PC_W-1:0] PC_STEP  = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [PC_W-1:0] TRAP_VEC = 32'h0000_1000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_HOLD = 2'd1,
        SEL_BR   = 2'd2,
        SEL_JMP  = 2'd3
    } pc_sel_e;

    // Redirect targets must be word aligned.
    function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sel_mux.sv
// pc_sel_mux: combinational next-PC source mux.
//   sel        : 2-bit source select (SEQ/HOLD/BR/JMP)
//   rst_sel    : force RESET_PC (highest)
//   trap_sel   : force TRAP_VEC (above sel)
//   pc         : current PC
//   br_target  : EX branch target
//   jmp_target : ID jump target
//   next_pc    : selected next PC
module pc_sel_mux
    import pc_ctrl_pkg::*;
(
    input  pc_sel_e         sel,
    input  logic            rst_sel,
    input  logic            trap_sel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] jmp_target,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] pc_plus;

    // Sequential increment wraps naturally at 2^32.
    assign pc_plus = PC_W'(pc + PC_STEP);

    always_comb begin
        next_pc = pc_plus;
        if (rst_sel) begin
            next_pc = RESET_PC;
        end else if (trap_sel) begin
            next_pc = TRAP_VEC;
        end else begin
            unique case (sel)
                SEL_SEQ:  next_pc = pc_plus;
                SEL_HOLD: next_pc = pc;
                SEL_BR:   next_pc = br_target;
                SEL_JMP:  next_pc = jmp_target;
            endcase
        end
    end

endmodule

// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl: next-PC sequencing policy for the fetch stage.
// Chooses PC+4, branch target, jump target or hold; drives IF/ID and ID/EX
// flushes; tracks halt; counts accepted redirects.
// Optional feature macro: PC_TRAP_EN (misaligned redirect traps to TRAP_VEC).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   pc             : current PC register value
//   stall_req      : load-use hazard, hold PC
//   br_taken/br_target   : EX-stage taken branch
//   jmp_valid/jmp_target : ID-stage jump
//   halt           : halt retiring in WB
//   next_pc        : PC register D input (combinational)
//   if_flush, id_flush : pipeline bubbles (combinational)
//   halted         : in HALTED state (registered)
//   redirect_cnt   : accepted redirect count (registered, wraps)
//   trap, epc      : misaligned redirect pulse / faulting target (registered)
module pc_next_ctrl
    import pc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic              stall_req,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              jmp_valid,
    input  logic [PC_W-1:0]   jmp_target,
    input  logic              halt,
    output logic [PC_W-1:0]   next_pc,
    output logic              if_flush,
    output logic              id_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic              trap,
    output logic [PC_W-1:0]   epc
);

    pc_state_e        state_q, state_d;
    pc_sel_e          sel;
    logic             rst_sel;
    logic             trap_hit;
    logic             cnt_inc;
    logic [PC_W-1:0]  fault_addr;
    logic [CNT_W-1:0] cnt_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority decode: next state, select and flushes.
    always_comb begin
        state_d    = state_q;
        sel        = SEL_SEQ;
        rst_sel    = 1'b0;
        trap_hit   = 1'b0;
        cnt_inc    = 1'b0;
        fault_addr = br_target;
        if_flush   = 1'b0;
        id_flush   = 1'b0;

        if (rst) begin
            rst_sel  = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
            state_d  = ST_RUN;
        end else if (state_q == ST_HALTED) begin
            sel      = SEL_HOLD;
            if_flush = 1'b1;
        end else if (halt) begin
            sel      = SEL_HOLD;
            if_flush = 1'b1;
            id_flush = 1'b1;
            state_d  = ST_HALTED;
        end else if (br_taken) begin
            // Branch in EX is older than a stalled ID, so it wins over stall.
            sel      = SEL_BR;
            if_flush = 1'b1;
            id_flush = 1'b1;
            cnt_inc  = 1'b1;
`ifdef PC_TRAP_EN
            fault_addr = br_target;
            trap_hit   = is_misaligned(br_target);
`endif
        end else if (stall_req) begin
            // Jump stays parked in ID until the stall clears.
            sel      = SEL_HOLD;
            id_flush = 1'b1;
        end else if (jmp_valid) begin
            sel      = SEL_JMP;
            if_flush = 1'b1;
            cnt_inc  = 1'b1;
`ifdef PC_TRAP_EN
            fault_addr = jmp_target;
            trap_hit   = is_misaligned(jmp_target);
            if (trap_hit) begin
                id_flush = 1'b1;
            end
`endif
        end
    end

    pc_sel_mux u_pc_sel_mux (
        .sel        (sel),
        .rst_sel    (rst_sel),
        .trap_sel   (trap_hit),
        .pc         (pc),
        .br_target  (br_target),
        .jmp_target (jmp_target),
        .next_pc    (next_pc)
    );

    // Redirect counter, wraps at 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= CNT_W'(cnt_q + 16'd1);
        end
    end

    assign redirect_cnt = cnt_q;
    assign halted       = (state_q == ST_HALTED);

`ifdef PC_TRAP_EN
    logic            trap_q;
    logic [PC_W-1:0] epc_q;

    // One-cycle trap pulse and faulting-target capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
            epc_q  <= '0;
        end else begin
            trap_q <= trap_hit;
            if (trap_hit) begin
                epc_q <= fault_addr;
            end
        end
    end

    assign trap = trap_q;
    assign epc  = epc_q;
`else
    logic unused_fault;
    assign unused_fault = ^{trap_hit, fault_addr};
    assign trap = 1'b0;
    assign epc  = '0;
`endif

endmodule

// File: tb/tb_pc_next_ctrl.sv
// tb_pc_next_ctrl: directed self-checking bench for pc_next_ctrl.
module tb_pc_next_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        stall_req;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        halt;
    logic [31:0] next_pc;
    logic        if_flush;
    logic        id_flush;
    logic        halted;
    logic [15:0] redirect_cnt;
    logic        trap;
    logic [31:0] epc;

    int errors = 0;
    int checks = 0;

    pc_next_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .stall_req    (stall_req),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .halt         (halt),
        .next_pc      (next_pc),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .halted       (halted),
        .redirect_cnt (redirect_cnt),
        .trap         (trap),
        .epc          (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        stall_req  = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        jmp_valid  = 1'b0;
        jmp_target = 32'h0;
        halt       = 1'b0;
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'd0; exp_seq[1] = 32'd4; exp_seq[2] = 32'd8; exp_seq[3] = 32'd12;
        idle_inputs();
        rst = 1'b1;
        pc  = 32'h1234_5678;
        tick();
        tick();
        checks++;
        if (next_pc !== 32'h0 || if_flush !== 1'b1 || id_flush !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb: next_pc=%h if=%b id=%b, want 0 1 1", next_pc, if_flush, id_flush);
        end
        checks++;
        if (halted !== 1'b0 || redirect_cnt !== 16'h0 || trap !== 1'b0 || epc !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: halted=%b cnt=%h trap=%b epc=%h, want 0 0 0 0",
                     halted, redirect_cnt, trap, epc);
        end
        pc = 32'h0;
        rst = 1'b0;
        #1;
        // Feed next_pc back as the PC register would.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (next_pc !== exp_seq[i] + 32'd4 || if_flush !== 1'b0 || id_flush !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: next_pc=%h if=%b id=%b, want %h 0 0",
                         i, next_pc, if_flush, id_flush, exp_seq[i] + 32'd4);
            end
            checks++;
            if (pc !== exp_seq[i]) begin
                errors++;
                $display("FAIL pc_seq_%0d: pc=%h, want %h", i, pc, exp_seq[i]);
            end
            tick();
            pc = next_pc;
            #1;
        end
        checks++;
        if (redirect_cnt !== 16'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL idle_regs: cnt=%h halted=%b, want 0 0", redirect_cnt, halted);
        end
    endtask

    task automatic test_wrap();
        idle_inputs();
        pc = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (next_pc !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: next_pc=%h, want 00000000", next_pc);
        end
        tick();
    endtask

    task automatic test_stall();
        idle_inputs();
        pc = 32'h40;
        stall_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (next_pc !== 32'h40 || id_flush !== 1'b1 || if_flush !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: next_pc=%h if=%b id=%b, want 40 0 1",
                         i, next_pc, if_flush, id_flush);
            end
            tick();
        end
        checks++;
        if (redirect_cnt !== 16'h0) begin
            errors++;
            $display("FAIL stall_cnt: cnt=%h, want 0", redirect_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_br_over_stall();
        idle_inputs();
        pc = 32'h40;
        stall_req = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h100;
        #1;
        checks++;
        if (next_pc !== 32'h100 || if_flush !== 1'b1 || id_flush !== 1'b1) begin
            errors++;
            $display("FAIL br_stall: next_pc=%h if=%b id=%b, want 100 1 1", next_pc, if_flush, id_flush);
        end
        tick();
        checks++;
        if (redirect_cnt !== 16'h1) begin
            errors++;
            $display("FAIL br_cnt: cnt=%h, want 1", redirect_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_jmp_held();
        idle_inputs();
        pc = 32'h80;
        stall_req  = 1'b1;
        jmp_valid  = 1'b1;
        jmp_target = 32'h200;
        #1;
        checks++;
        if (next_pc !== 32'h80 || if_flush !== 1'b0 || id_flush !== 1'b1) begin
            errors++;
            $display("FAIL jmp_held: next_pc=%h if=%b id=%b, want 80 0 1", next_pc, if_flush, id_flush);
        end
        tick();
        checks++;
        if (redirect_cnt !== 16'h1) begin
            errors++;
            $display("FAIL jmp_held_cnt: cnt=%h, want 1", redirect_cnt);
        end
        stall_req = 1'b0;
        #1;
        checks++;
        if (next_pc !== 32'h200 || if_flush !== 1'b1 || id_flush !== 1'b0) begin
            errors++;
            $display("FAIL jmp_go: next_pc=%h if=%b id=%b, want 200 1 0", next_pc, if_flush, id_flush);
        end
        tick();
        checks++;
        if (redirect_cnt !== 16'h2) begin
            errors++;
            $display("FAIL jmp_cnt: cnt=%h, want 2", redirect_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_rst_abort();
        idle_inputs();
        pc = 32'h300;
        br_taken  = 1'b1;
        br_target = 32'h500;
        rst = 1'b1;
        #1;
        checks++;
        if (next_pc !== 32'h0 || if_flush !== 1'b1 || id_flush !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort: next_pc=%h if=%b id=%b, want 0 1 1", next_pc, if_flush, id_flush);
        end
        tick();
        checks++;
        if (redirect_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_abort_cnt: cnt=%h, want 0", redirect_cnt);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_cnt_wrap();
        idle_inputs();
        pc = 32'h10;
        jmp_valid  = 1'b1;
        jmp_target = 32'h20;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (redirect_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_max: cnt=%h, want ffff", redirect_cnt);
        end
        tick();
        checks++;
        if (redirect_cnt !== 16'h0) begin
            errors++;
            $display("FAIL cnt_wrap: cnt=%h, want 0", redirect_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        idle_inputs();
        pc = 32'h600;
        halt = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h700;
        #1;
        checks++;
        if (next_pc !== 32'h600 || if_flush !== 1'b1 || id_flush !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_comb: next_pc=%h if=%b id=%b halted=%b, want 600 1 1 0",
                     next_pc, if_flush, id_flush, halted);
        end
        tick();
        halt = 1'b0;
        // Redirect requests must be ignored while halted.
        jmp_valid  = 1'b1;
        jmp_target = 32'h800;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (halted !== 1'b1 || next_pc !== 32'h600 || if_flush !== 1'b1 || id_flush !== 1'b0
                || redirect_cnt !== 16'h0) begin
                errors++;
                $display("FAIL halted_%0d: halted=%b next_pc=%h if=%b id=%b cnt=%h, want 1 600 1 0 0",
                         i, halted, next_pc, if_flush, id_flush, redirect_cnt);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (next_pc !== 32'h0) begin
            errors++;
            $display("FAIL halt_rst_pc: next_pc=%h, want 0", next_pc);
        end
        tick();
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_rst: halted=%b, want 0", halted);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

`ifdef PC_TRAP_EN
    task automatic test_trap();
        idle_inputs();
        pc = 32'h40;
        br_taken  = 1'b1;
        br_target = 32'h102;
        #1;
        checks++;
        if (next_pc !== 32'h1000 || if_flush !== 1'b1 || id_flush !== 1'b1) begin
            errors++;
            $display("FAIL trap_comb: next_pc=%h if=%b id=%b, want 1000 1 1", next_pc, if_flush, id_flush);
        end
        tick();
        br_taken = 1'b0;
        #1;
        checks++;
        if (trap !== 1'b1 || epc !== 32'h102 || redirect_cnt !== 16'h1) begin
            errors++;
            $display("FAIL trap_pulse: trap=%b epc=%h cnt=%h, want 1 102 1", trap, epc, redirect_cnt);
        end
        tick();
        checks++;
        if (trap !== 1'b0 || epc !== 32'h102) begin
            errors++;
            $display("FAIL trap_clear: trap=%b epc=%h, want 0 102", trap, epc);
        end
        idle_inputs();
    endtask
`else
    task automatic test_misaligned_passthru();
        idle_inputs();
        pc = 32'h40;
        br_taken  = 1'b1;
        br_target = 32'h102;
        #1;
        checks++;
        if (next_pc !== 32'h102 || if_flush !== 1'b1 || id_flush !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_br: next_pc=%h if=%b id=%b, want 102 1 1", next_pc, if_flush, id_flush);
        end
        tick();
        br_taken = 1'b0;
        #1;
        checks++;
        if (trap !== 1'b0 || epc !== 32'h0 || redirect_cnt !== 16'h1) begin
            errors++;
            $display("FAIL no_trap: trap=%b epc=%h cnt=%h, want 0 0 1", trap, epc, redirect_cnt);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        pc  = 32'h0;
        idle_inputs();
        test_reset();
        test_wrap();
        test_stall();
        test_br_over_stall();
        test_jmp_held();
        test_rst_abort();
        test_cnt_wrap();
        test_halt();
`ifdef PC_TRAP_EN
        test_trap();
`else
        test_misaligned_passthru();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
